// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM write arbiter: FSM states, address step,
// drop-counter width and the round-robin grant search.
package sdram_arb_pkg;

    typedef enum logic {
        IDLE,
        WRITE
    } arb_state_t;

    localparam int ADDR_STEP = 8;
    localparam int DROP_W    = 16;

    // First requester after 'last' in circular order; returns 'last' when nobody requests.
    function automatic logic [2:0] rr_next(input logic [7:0] req, input logic [2:0] last, input int num);
        logic [2:0] pick;
        int         idx;
        pick = last;
        for (int k = 8; k >= 1; k--) begin
            idx = (int'(last) + k) % num;
            if (k <= num && req[idx]) begin
                pick = 3'(idx);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sdram_arb_chan.sv
// One capture channel: single-entry sample buffer, ring write pointer with wrap and
// an optional saturating drop counter (enabled by `define SDRAM_ARB_DROP_CNT_EN).
module sdram_arb_chan
    import sdram_arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RBUF_WORDS = 2500,
    parameter int PTR_W      = (RBUF_WORDS > 1) ? $clog2(RBUF_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic              accept,
    output logic              pend,
    output logic [DATA_W-1:0] hold,
    output logic [PTR_W-1:0]  wptr,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [PTR_W-1:0] LAST_WORD = PTR_W'(RBUF_WORDS - 1);

    // A new sample may refill the buffer in the same cycle the old one is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= 1'b0;
            hold <= '0;
            wptr <= '0;
        end else begin
            if (valid && (!pend || accept)) begin
                hold <= data;
                pend <= 1'b1;
            end else if (accept) begin
                pend <= 1'b0;
            end
            if (accept) begin
                wptr <= (wptr == LAST_WORD) ? '0 : wptr + 1'b1;
            end
        end
    end

`ifdef SDRAM_ARB_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (valid && pend && !accept && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: rtl/sdram_write_arbiter.sv
// Round-robin sharing of one 64-bit Avalon-MM write master among NUM_CH capture rings,
// with write-pointer snapshot on interrupt. Drop counters need `define SDRAM_ARB_DROP_CNT_EN.
module sdram_write_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          DATA_W     = 32,
    parameter int          RBUF_WORDS = 2500,
    parameter logic [31:0] CH_STRIDE  = 32'h0001_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [31:0]              mem_addr,
    input  logic [7:0]               interrupt_id,
    output logic [31:0]              address,
    output logic                     write_en,
    output logic [63:0]              writedata,
    input  logic                     waitrequest,
    output logic [NUM_CH*32-1:0]     end_address,
    output logic [NUM_CH*DROP_W-1:0] drop_cnt
);

    localparam int GW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = (RBUF_WORDS > 1) ? $clog2(RBUF_WORDS) : 1;

    arb_state_t        state, state_next;
    logic [GW-1:0]     grant, grant_next, last_grant, last_grant_next, pick;
    logic [31:0]       address_next;
    logic              write_en_next;
    logic [63:0]       writedata_next;
    logic              accept;
    logic [NUM_CH-1:0] pend, ch_accept;
    logic [DATA_W-1:0] hold [NUM_CH];
    logic [PTR_W-1:0]  wptr [NUM_CH];

    assign accept = (state == WRITE) && !waitrequest;
    assign pick   = GW'(rr_next(8'(pend), 3'(last_grant), NUM_CH));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_accept[i] = accept && (grant == GW'(i));

        sdram_arb_chan #(
            .DATA_W     (DATA_W),
            .RBUF_WORDS (RBUF_WORDS),
            .PTR_W      (PTR_W)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .valid    (ch_valid[i]),
            .data     (ch_data[i*DATA_W +: DATA_W]),
            .accept   (ch_accept[i]),
            .pend     (pend[i]),
            .hold     (hold[i]),
            .wptr     (wptr[i]),
            .drop_cnt (drop_cnt[i*DROP_W +: DROP_W])
        );
    end

    // mem_addr and the channel buffer are captured only at issue, so the bus stays stable in WRITE.
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        write_en_next   = write_en;
        address_next    = address;
        writedata_next  = writedata;
        unique case (state)
            IDLE: begin
                if (|pend) begin
                    state_next     = WRITE;
                    grant_next     = pick;
                    write_en_next  = 1'b1;
                    address_next   = mem_addr + 32'(pick) * CH_STRIDE + 32'(wptr[pick]) * 32'(ADDR_STEP);
                    writedata_next = 64'(hold[pick]);
                end
            end
            WRITE: begin
                if (!waitrequest) begin
                    state_next      = IDLE;
                    last_grant_next = grant;
                    write_en_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_CH - 1);
            write_en   <= 1'b0;
            address    <= '0;
            writedata  <= '0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            write_en   <= write_en_next;
            address    <= address_next;
            writedata  <= writedata_next;
        end
    end

    // Snapshot uses the registered pointers, so a same-cycle advance reports its old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            end_address <= '0;
        end else if (interrupt_id != 8'd0) begin
            for (int i = 0; i < NUM_CH; i++) begin
                end_address[i*32 +: 32] <= 32'(wptr[i]) * 32'(ADDR_STEP);
            end
        end
    end

endmodule

// File: tb/tb_sdram_write_arbiter.sv
// Self-checking bench for sdram_write_arbiter: a per-cycle vector table for latency,
// fairness, backpressure and drops, then hand sequences for snapshot, reset and ring wrap.
module tb_sdram_write_arbiter;

    localparam logic [31:0] M     = 32'h1000_0000;
    localparam logic [31:0] S     = 32'h0001_0000;
`ifdef SDRAM_ARB_DROP_CNT_EN
    localparam logic [15:0] DROPV = 16'd1;
`else
    localparam logic [15:0] DROPV = 16'd0;
`endif

    logic         clk;
    logic         reset;
    logic [3:0]   ch_valid;
    logic [127:0] ch_data;
    logic [31:0]  mem_addr;
    logic [7:0]   interrupt_id;
    logic [31:0]  address;
    logic         write_en;
    logic [63:0]  writedata;
    logic         waitrequest;
    logic [127:0] end_address;
    logic [63:0]  drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    sdram_write_arbiter #(
        .NUM_CH     (4),
        .DATA_W     (32),
        .RBUF_WORDS (4),
        .CH_STRIDE  (S)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ch_valid     (ch_valid),
        .ch_data      (ch_data),
        .mem_addr     (mem_addr),
        .interrupt_id (interrupt_id),
        .address      (address),
        .write_en     (write_en),
        .writedata    (writedata),
        .waitrequest  (waitrequest),
        .end_address  (end_address),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs held for one cycle, expected outputs just after that cycle's edge.
    typedef struct {
        logic [3:0]   valid;
        logic [127:0] data;
        logic [31:0]  mem;
        logic         wait_req;
        logic         exp_wen;
        logic [31:0]  exp_addr;
        logic [63:0]  exp_wdata;
        logic [15:0]  exp_drop0;
    } vec_t;

    vec_t vecs [22];

    task automatic checkOutput(input string name, input int step, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s step %0d: got %0h, expected %0h", name, step, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ch_valid    = v.valid;
        ch_data     = v.data;
        mem_addr    = v.mem;
        waitrequest = v.wait_req;
    endtask

    // Single sample on one channel, waits for its write, checks the bus and accepts it.
    task automatic doWrite(input int ch, input logic [31:0] d, input logic [7:0] irq,
                           input logic [31:0] exp_a, input int step);
        int n;
        @(negedge clk);
        waitrequest        = 1'b0;
        ch_valid           = 4'b0001 << ch;
        ch_data            = '0;
        ch_data[ch*32 +: 32] = d;
        @(negedge clk);
        ch_valid = '0;
        n = 0;
        while (!write_en && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wr_en", step, 64'(write_en), 64'd1);
        checkOutput("wr_addr", step, 64'(address), 64'(exp_a));
        checkOutput("wr_data", step, writedata, 64'(d));
        interrupt_id = irq;
        @(negedge clk);
        interrupt_id = 8'd0;
        checkOutput("wr_done", step, 64'(write_en), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{4'b0100, {32'h0, 32'hDEAD_BEEF, 64'h0}, M, 1'b0, 1'b0, 32'h0, 64'h0, 16'd0};
        vecs[1]  = '{4'b0000, 128'h0, M, 1'b0, 1'b1, 32'h1002_0000, 64'h0000_0000_DEAD_BEEF, 16'd0};
        vecs[2]  = '{4'b0000, 128'h0, M, 1'b0, 1'b0, 32'h0, 64'h0, 16'd0};
        vecs[3]  = '{4'b1111, {32'hA333_3333, 32'hA222_2222, 32'hA111_1111, 32'hA000_0000},
                     M, 1'b0, 1'b0, 32'h0, 64'h0, 16'd0};
        vecs[4]  = '{4'b0000, 128'h0, M, 1'b0, 1'b1, 32'h1003_0000, 64'hA333_3333, 16'd0};
        vecs[5]  = '{4'b0000, 128'h0, M, 1'b0, 1'b0, 32'h0, 64'h0, 16'd0};
        vecs[6]  = '{4'b0000, 128'h0, M, 1'b0, 1'b1, 32'h1000_0000, 64'hA000_0000, 16'd0};
        vecs[7]  = '{4'b0000, 128'h0, M, 1'b0, 1'b0, 32'h0, 64'h0, 16'd0};
        vecs[8]  = '{4'b0000, 128'h0, M, 1'b0, 1'b1, 32'h1001_0000, 64'hA111_1111, 16'd0};
        vecs[9]  = '{4'b0000, 128'h0, M, 1'b0, 1'b0, 32'h0, 64'h0, 16'd0};
        vecs[10] = '{4'b0000, 128'h0, M, 1'b0, 1'b1, 32'h1002_0008, 64'hA222_2222, 16'd0};
        vecs[11] = '{4'b0000, 128'h0, M, 1'b0, 1'b0, 32'h0, 64'h0, 16'd0};
        vecs[12] = '{4'b0001, {96'h0, 32'hB000_000B}, M, 1'b0, 1'b0, 32'h0, 64'h0, 16'd0};
        vecs[13] = '{4'b0000, 128'h0, M, 1'b1, 1'b1, 32'h1000_0008, 64'hB000_000B, 16'd0};
        vecs[14] = '{4'b0000, 128'h0, M, 1'b1, 1'b1, 32'h1000_0008, 64'hB000_000B, 16'd0};
        vecs[15] = '{4'b0001, {96'h0, 32'hC000_000C}, M, 1'b1, 1'b1, 32'h1000_0008, 64'hB000_000B, DROPV};
        vecs[16] = '{4'b0000, 128'h0, 32'h2000_0000, 1'b1, 1'b1, 32'h1000_0008, 64'hB000_000B, DROPV};
        vecs[17] = '{4'b0000, 128'h0, M, 1'b1, 1'b1, 32'h1000_0008, 64'hB000_000B, DROPV};
        vecs[18] = '{4'b0000, 128'h0, M, 1'b1, 1'b1, 32'h1000_0008, 64'hB000_000B, DROPV};
        vecs[19] = '{4'b0001, {96'h0, 32'hD000_000D}, M, 1'b0, 1'b0, 32'h0, 64'h0, DROPV};
        vecs[20] = '{4'b0000, 128'h0, M, 1'b0, 1'b1, 32'h1000_0010, 64'hD000_000D, DROPV};
        vecs[21] = '{4'b0000, 128'h0, M, 1'b0, 1'b0, 32'h0, 64'h0, DROPV};

        reset        = 1'b1;
        ch_valid     = '0;
        ch_data      = '0;
        mem_addr     = M;
        interrupt_id = 8'd0;
        waitrequest  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_wen", 0, 64'(write_en), 64'd0);
        checkOutput("rst_addr", 0, 64'(address), 64'd0);
        checkOutput("rst_wdata", 0, writedata, 64'd0);
        checkOutput("rst_end_lo", 0, end_address[63:0], 64'd0);
        checkOutput("rst_end_hi", 0, end_address[127:64], 64'd0);
        checkOutput("rst_drop", 0, drop_cnt, 64'd0);
        reset = 1'b0;

        // Latency, round-robin order from last_grant=2, stall with drop and mem_addr change.
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput("tbl_wen", i, 64'(write_en), 64'(vecs[i].exp_wen));
            if (vecs[i].exp_wen) begin
                checkOutput("tbl_addr", i, 64'(address), 64'(vecs[i].exp_addr));
                checkOutput("tbl_wdata", i, writedata, vecs[i].exp_wdata);
            end
            checkOutput("tbl_drop0", i, 64'(drop_cnt[15:0]), 64'(vecs[i].exp_drop0));
            @(negedge clk);
        end
        applyStimulus('{4'b0000, 128'h0, M, 1'b0, 1'b0, 32'h0, 64'h0, 16'd0});

        // Idle snapshot: wptr = {ch3:1, ch2:2, ch1:1, ch0:3}.
        interrupt_id = 8'h05;
        @(negedge clk);
        interrupt_id = 8'd0;
        checkOutput("snap_end0", 100, 64'(end_address[31:0]), 64'd24);
        checkOutput("snap_end1", 100, 64'(end_address[63:32]), 64'd8);
        checkOutput("snap_end2", 100, 64'(end_address[95:64]), 64'd16);
        checkOutput("snap_end3", 100, 64'(end_address[127:96]), 64'd8);

        // Reset while a write is stalled.
        ch_valid    = 4'b0001;
        ch_data     = {96'h0, 32'hE000_000E};
        waitrequest = 1'b1;
        @(negedge clk);
        ch_valid = '0;
        @(negedge clk);
        checkOutput("stall_wen", 200, 64'(write_en), 64'd1);
        checkOutput("stall_addr", 200, 64'(address), 64'h1000_0018);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst2_wen", 201, 64'(write_en), 64'd0);
        checkOutput("rst2_drop", 201, drop_cnt, 64'd0);
        checkOutput("rst2_end", 201, end_address[63:0], 64'd0);
        reset       = 1'b0;
        waitrequest = 1'b0;
        @(negedge clk);

        // Post-reset ch0 writes restart at offset 0; snapshot in acceptance cycle of write 3.
        doWrite(0, 32'hF000_0000, 8'h00, M + 32'd0,  300);
        doWrite(0, 32'hF000_0001, 8'h00, M + 32'd8,  301);
        doWrite(0, 32'hF000_0002, 8'h01, M + 32'd16, 302);
        checkOutput("acc_snap_end0", 303, 64'(end_address[31:0]), 64'd16);
        checkOutput("acc_snap_end1", 303, 64'(end_address[63:32]), 64'd0);
        interrupt_id = 8'h01;
        @(negedge clk);
        interrupt_id = 8'd0;
        checkOutput("late_snap_end0", 304, 64'(end_address[31:0]), 64'd24);

        // Ring wrap on ch1 with RBUF_WORDS=4.
        doWrite(1, 32'h1111_0000, 8'h00, M + S + 32'd0,  400);
        doWrite(1, 32'h1111_0001, 8'h00, M + S + 32'd8,  401);
        doWrite(1, 32'h1111_0002, 8'h00, M + S + 32'd16, 402);
        doWrite(1, 32'h1111_0003, 8'h00, M + S + 32'd24, 403);
        doWrite(1, 32'h1111_0004, 8'h00, M + S + 32'd0,  404);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_write_arbiter.md
# sdram_write_arbiter

Shares the single 64-bit Avalon-MM SDRAM write master between `NUM_CH` free-running capture channels. Each channel owns a private ring buffer in SDRAM at `mem_addr + ch*CH_STRIDE`. The block buffers one sample per channel, grants the master round-robin, and advances per-channel write pointers with wrap-around. It snapshots all write pointers on an interrupt so software knows where each ring ends.

## Interface
Parameters:
- `NUM_CH`, 4: number of capture channels (2..8)
- `DATA_W`, 32: sample width, at most 64
- `RBUF_WORDS`, 2500: ring length per channel, in 64-bit words
- `CH_STRIDE`, 32'h0001_0000: byte distance between channel ring bases

Ports:
- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `ch_valid` in NUM_CH: one-cycle sample strobe per channel; no backpressure
- `ch_data` in NUM_CH*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W]
- `mem_addr` in 32: byte base address of the ring region
- `interrupt_id` in 8: nonzero requests a pointer snapshot
- `address` out 32: Avalon byte address
- `write_en` out 1: Avalon write
- `writedata` out 64: Avalon write data
- `waitrequest` in 1: Avalon stall
- `end_address` out NUM_CH*32: per-channel snapshot byte offset
- `drop_cnt` out NUM_CH*16: per-channel dropped-sample count

## Operation
- Per-channel state:
  - `pend` flag and `hold` register (one-entry buffer)
  - `wptr` word index, 0..RBUF_WORDS-1
  - drop counter
- Load rule: when `ch_valid[i]` is high and `pend[i]` is 0, or `pend[i]` is being cleared this cycle, the block loads `hold[i]` and sets `pend[i]`.
- Drop rule: when `ch_valid[i]` is high while `pend[i]` is held, the sample is discarded and the drop counter increments, saturating at 16'hFFFF.
- State machine, IDLE / WRITE:
  - IDLE: if any `pend` is set, pick channel g by round-robin starting at `last_grant+1` (mod NUM_CH). Register `write_en=1`, `address = mem_addr + g*CH_STRIDE + wptr[g]*8` (32-bit, wraps mod 2^32), and `writedata = {zero-extend, hold[g]}`. Go to WRITE.
  - WRITE: hold `address`, `writedata` and `write_en` stable while `waitrequest=1`. On a cycle with `waitrequest=0`, the write is accepted:
    - clear `pend[g]`
    - set `wptr[g]` to `wptr[g]+1`, or 0 when `wptr[g]==RBUF_WORDS-1`
    - set `last_grant=g`
    - deassert `write_en` next cycle and return to IDLE
- Snapshot: when `interrupt_id != 0`, set `end_address[i] <= wptr[i]*8` for all i. A pointer advancing in the same cycle contributes its pre-increment value.
- `mem_addr` is sampled only at issue (IDLE→WRITE). Changes during WRITE have no effect on the transfer in flight.

## Timing
- Reset values:
  - `write_en=0`, `address=0`, `writedata=0`
  - `end_address=0`, `drop_cnt=0`
  - all `pend`/`wptr`=0, `last_grant=NUM_CH-1`, state IDLE
- Latency: `ch_valid` in cycle N gives `pend` set in N+1 and `write_en` in N+2, provided the arbiter is idle.
- Throughput: at most one accepted write per 2 cycles, whatever the channel count.
- Simultaneous acceptance and new sample on the granted channel: the new sample loads and no drop is counted.
- Reset during WRITE: the transfer is abandoned and `write_en=0` the next cycle. Software accepts the lost word.
- Ring wrap: the write after word RBUF_WORDS-1 goes to offset 0.

## Configuration
- `SDRAM_ARB_DROP_CNT_EN`:
  - Defined: drop counters are implemented as described.
  - Undefined: no counter logic. `drop_cnt` is driven constant 0 and drops still occur silently.

## Structure
- Package `sdram_arb_pkg`: state enum (IDLE, WRITE), `ADDR_STEP=8`, drop-counter width 16, and a round-robin next-grant function.
- Sub-module `sdram_arb_chan`, instantiated once per channel, holds `hold`/`pend`, `wptr` with wrap, and the drop counter. The top level holds the FSM, the Avalon registers and the snapshot.

## Test plan
- Single sample: `mem_addr=32'h1000_0000`, ch2 `ch_valid` with data 32'hDEAD_BEEF, `waitrequest=0` → 2 cycles later one write to 32'h1002_0000 with data 64'h0000_0000_DEAD_BEEF; ch2 `wptr` becomes 1.
- Fairness: all 4 channels pending, `last_grant=3` → grants in order 0,1,2,3, each write_en pulse 1 cycle with one idle cycle between.
- Backpressure: `waitrequest=1` for 5 cycles mid-write → address and data stable throughout, exactly one acceptance; a second ch0 sample during the stall increments drop_cnt[0] to 1 (macro defined) or leaves it 0 (undefined).
- Wrap: RBUF_WORDS=4, 5 samples on ch1 → offsets 0,8,16,24,0 relative to `mem_addr+CH_STRIDE`.
- Snapshot: `interrupt_id=8'h01` in the acceptance cycle of ch0 write 3 → end_address[0]=16, then a later snapshot gives 24.
- Reset mid-WRITE with `waitrequest=1` → `write_en=0` next cycle, all pointers and counters 0, first write after release goes to offset 0.
